// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_COLLECT,
    LD_WRITE,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, control/status and instruction-memory write port of the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 5
);
  import loader_pkg::*;

  logic              start;
  logic              abort;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              write_ins;
  logic [ADDR_W-1:0] ins_address;
  logic [WORD_W-1:0] ins;
  logic              busy;
  logic              done;
  logic [BYTE_W-1:0] checksum;

  modport master (
    output start, abort, byte_valid, byte_data,
    input  byte_ready, write_ins, ins_address, ins, busy, done, checksum
  );

  modport slave (
    input  start, abort, byte_valid, byte_data,
    output byte_ready, write_ins, ins_address, ins, busy, done, checksum
  );

endinterface

// File: rtl/word_packer.sv
// Little-endian byte-to-word assembly with a running XOR checksum of accepted bytes.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_full,
  output logic [BYTE_W-1:0] checksum
);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] asm_q;

  // Assembly register with the incoming byte merged at the current lane.
  always_comb begin
    word = asm_q;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (idx == IDX_W'(i)) word[i*BYTE_W +: BYTE_W] = byte_data;
    end
  end

  assign word_full = accept && (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      asm_q    <= '0;
      checksum <= '0;
    end else if (clear) begin
      idx      <= '0;
      asm_q    <= '0;
      checksum <= '0;
    end else if (accept) begin
      idx      <= idx + IDX_W'(1);
      asm_q    <= word;
      checksum <= checksum ^ byte_data;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Packs a host byte stream into 32-bit words and writes them to instruction memory from word 0.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input logic              clk,
  input logic              rst,
  program_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  ld_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] ins_q;
  logic [WORD_W-1:0] word;
  logic              word_full;
  logic [BYTE_W-1:0] checksum;
  logic              clear;
  logic              accept;

  // Abort wins over start and over a byte that would complete a word.
  assign clear  = bus.start && !bus.abort && (state == LD_IDLE || state == LD_DONE);
  assign accept = bus.byte_valid && !bus.abort && (state == LD_COLLECT);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .accept    (accept),
    .byte_data (bus.byte_data),
    .word      (word),
    .word_full (word_full),
    .checksum  (checksum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LD_IDLE;
      addr  <= '0;
      ins_q <= '0;
    end else if (bus.abort) begin
      state <= LD_IDLE;
      addr  <= '0;
    end else begin
      case (state)
        LD_IDLE, LD_DONE: begin
          if (bus.start) begin
            state <= LD_COLLECT;
            addr  <= '0;
          end
        end
        LD_COLLECT: begin
          if (word_full) begin
            state <= LD_WRITE;
            ins_q <= word;
          end
        end
        LD_WRITE: begin
          if (addr == LAST_ADDR) begin
            state <= LD_DONE;
          end else begin
            state <= LD_COLLECT;
            addr  <= addr + ADDR_W'(1);
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  // Status and write port decode straight from the state register.
  assign bus.byte_ready  = (state == LD_COLLECT);
  assign bus.write_ins   = (state == LD_WRITE);
  assign bus.busy        = (state == LD_COLLECT) || (state == LD_WRITE);
  assign bus.done        = (state == LD_DONE);
  assign bus.ins_address = addr;
  assign bus.ins         = ins_q;
  assign bus.checksum    = checksum;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench: one-word and 32-word loaders driven with random byte streams, gaps and aborts.
module tb_program_loader;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] w;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(5)) b1 ();
  program_loader_if #(.ADDR_W(5)) b32 ();

  program_loader #(.NUM_WORDS(1), .ADDR_W(5)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  program_loader #(.NUM_WORDS(32), .ADDR_W(5)) dut32 (.clk(clk), .rst(rst), .bus(b32));

  int checks = 0;
  int errors = 0;
  wr_t q1[$];
  wr_t q32[$];
  logic [7:0] cs_m[2];
  int widx[2];
  wr_t e1, e32;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors pop the expected write whenever a loader strobes its write port.
  always @(negedge clk) begin
    if (!rst && b1.write_ins) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write1: addr 0x%0h ins 0x%0h", b1.ins_address, b1.ins);
      end else begin
        e1 = q1.pop_front();
        check("addr1", 32'(b1.ins_address), 32'(e1.a));
        check("ins1", b1.ins, e1.w);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b32.write_ins) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write32: addr 0x%0h ins 0x%0h", b32.ins_address, b32.ins);
      end else begin
        e32 = q32.pop_front();
        check("addr32", 32'(b32.ins_address), 32'(e32.a));
        check("ins32", b32.ins, e32.w);
      end
      check("ready_in_write32", 32'(b32.byte_ready), 32'd0);
    end
  end

  function automatic logic rdy(input int which);
    return (which == 0) ? b1.byte_ready : b32.byte_ready;
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] d,
                        input logic s, input logic a);
    if (which == 0) begin
      b1.byte_valid = v; b1.byte_data = d; b1.start = s; b1.abort = a;
    end else begin
      b32.byte_valid = v; b32.byte_data = d; b32.start = s; b32.abort = a;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a byte and hold it until the loader takes it.
  task automatic send_byte(input int which, input logic [7:0] b);
    logic acc;
    set_in(which, 1'b1, b, 1'b0, 1'b0);
    for (int n = 0; n < 64; n++) begin
      acc = rdy(which);
      cyc();
      if (acc) begin
        cs_m[which] = cs_m[which] ^ b;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout: loader %0d never took byte 0x%0h", which, b);
  endtask

  task automatic start_load(input int which);
    set_in(which, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    set_in(which, 1'b0, 8'h00, 1'b0, 1'b0);
    cs_m[which] = 8'h00;
    widx[which] = 0;
  endtask

  task automatic push_exp(input int which, input logic [31:0] w);
    wr_t e;
    e.a = 5'(widx[which]);
    e.w = w;
    widx[which]++;
    if (which == 0) q1.push_back(e); else q32.push_back(e);
  endtask

  // Load n words; rnd selects random words with random gaps, start_at injects an ignored start.
  task automatic load_words(input int which, input int n, input bit rnd, input int start_at);
    logic [31:0] w;
    int gap;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom : {4{8'(i)}};
      push_exp(which, w);
      for (int j = 0; j < 4; j++) begin
        if (i == start_at && j == 2) begin
          set_in(which, 1'b0, 8'h00, 1'b1, 1'b0);
          cyc();
        end
        gap = rnd ? $urandom_range(0, 2) : 0;
        if (gap > 0) begin
          set_in(which, 1'b0, 8'h00, 1'b0, 1'b0);
          repeat (gap) cyc();
        end
        send_byte(which, w[8*j +: 8]);
      end
    end
    set_in(which, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_done32(input string tag);
    for (int n = 0; n < 20 && !b32.done; n++) cyc();
    check({tag, "_done"}, 32'(b32.done), 32'd1);
    check({tag, "_busy"}, 32'(b32.busy), 32'd0);
    check({tag, "_checksum"}, 32'(b32.checksum), 32'(cs_m[1]));
    check({tag, "_pending"}, q32.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
    cs_m[0] = 8'h00; cs_m[1] = 8'h00;
    widx[0] = 0; widx[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc();

    // Reset state.
    check("rst_ready", 32'(b32.byte_ready), 32'd0);
    check("rst_write", 32'(b32.write_ins), 32'd0);
    check("rst_busy", 32'(b32.busy), 32'd0);
    check("rst_done", 32'(b32.done), 32'd0);
    check("rst_addr", 32'(b32.ins_address), 32'd0);
    check("rst_ins", b32.ins, 32'd0);
    check("rst_checksum", 32'(b32.checksum), 32'd0);
    check("rst_done1", 32'(b1.done), 32'd0);

    // Single-word load, back-to-back bytes.
    start_load(0);
    check("w1_ready_after_start", 32'(b1.byte_ready), 32'd1);
    check("w1_busy_after_start", 32'(b1.busy), 32'd1);
    push_exp(0, 32'h12345678);
    send_byte(0, 8'h78);
    send_byte(0, 8'h56);
    send_byte(0, 8'h34);
    send_byte(0, 8'h12);
    set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("w1_write_cycle", 32'(b1.write_ins), 32'd1);
    check("w1_done_in_write", 32'(b1.done), 32'd0);
    cyc();
    check("w1_done", 32'(b1.done), 32'd1);
    check("w1_busy", 32'(b1.busy), 32'd0);
    check("w1_checksum", 32'(b1.checksum), 32'h08);
    check("w1_ins_held", b1.ins, 32'h12345678);
    check("w1_addr_held", 32'(b1.ins_address), 32'd0);
    check("w1_pending", q1.size(), 32'd0);

    // Full 32-word load with word n = {n,n,n,n}, byte_valid held through WRITE.
    start_load(1);
    load_words(1, 32, 1'b0, -1);
    wait_done32("full");

    // Random words with gaps and an ignored start mid-word.
    start_load(1);
    load_words(1, 32, 1'b1, 5);
    wait_done32("rand");

    // Abort after two bytes of word 3.
    start_load(1);
    load_words(1, 3, 1'b1, -1);
    send_byte(1, 8'hA5);
    send_byte(1, 8'h5A);
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("abort_busy", 32'(b32.busy), 32'd0);
    check("abort_done", 32'(b32.done), 32'd0);
    check("abort_ready", 32'(b32.byte_ready), 32'd0);
    check("abort_addr", 32'(b32.ins_address), 32'd0);
    check("abort_checksum", 32'(b32.checksum), 32'(cs_m[1]));
    repeat (3) cyc();
    start_load(1);
    load_words(1, 32, 1'b1, -1);
    wait_done32("reload");

    // Abort coinciding with the byte that would complete word 0.
    start_load(1);
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    send_byte(1, 8'h33);
    set_in(1, 1'b1, 8'h44, 1'b1, 1'b1);
    cyc();
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("abort4_write", 32'(b32.write_ins), 32'd0);
    check("abort4_busy", 32'(b32.busy), 32'd0);
    check("abort4_addr", 32'(b32.ins_address), 32'd0);
    check("abort4_checksum", 32'(b32.checksum), 32'(cs_m[1]));
    cyc();
    check("abort4_no_write", 32'(b32.write_ins), 32'd0);

    // Asynchronous reset in the middle of a WRITE cycle.
    start_load(1);
    send_byte(1, 8'hDE);
    send_byte(1, 8'hAD);
    send_byte(1, 8'hBE);
    set_in(1, 1'b1, 8'hEF, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("rw_write_before", 32'(b32.write_ins), 32'd1);
    rst = 1'b1;
    #1;
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rw_write", 32'(b32.write_ins), 32'd0);
    check("rw_busy", 32'(b32.busy), 32'd0);
    check("rw_done", 32'(b32.done), 32'd0);
    check("rw_ready", 32'(b32.byte_ready), 32'd0);
    check("rw_addr", 32'(b32.ins_address), 32'd0);
    check("rw_ins", b32.ins, 32'd0);
    check("rw_checksum", 32'(b32.checksum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cyc();
    check("end_pending1", q1.size(), 32'd0);
    check("end_pending32", q32.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
